// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Package : fetch_pkg
// Brief   : Shared types, jump condition codes, opcode format masks and the
//           extension-word counter for the MSP430 fetch/decode stage.
// Rev     : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Decoder state: where the next accepted word belongs.
  typedef enum logic [2:0] {
    ST_OPCODE = 3'd0,
    ST_EXT1   = 3'd1,
    ST_EXT2   = 3'd2,
    ST_FLUSH1 = 3'd3,
    ST_FLUSH2 = 3'd4
  } fetch_state_t;

  // Format-III condition field [12:10].
  localparam logic [2:0] c_COND_JNE = 3'd0;
  localparam logic [2:0] c_COND_JEQ = 3'd1;
  localparam logic [2:0] c_COND_JNC = 3'd2;
  localparam logic [2:0] c_COND_JC  = 3'd3;
  localparam logic [2:0] c_COND_JN  = 3'd4;
  localparam logic [2:0] c_COND_JGE = 3'd5;
  localparam logic [2:0] c_COND_JL  = 3'd6;
  localparam logic [2:0] c_COND_JMP = 3'd7;

  // Opcode format masks (word & MASK) == MATCH.
  localparam logic [15:0] c_FMT2_MASK  = 16'hFC00;
  localparam logic [15:0] c_FMT2_MATCH = 16'h1000;
  localparam logic [15:0] c_FMT3_MASK  = 16'hE000;
  localparam logic [15:0] c_FMT3_MATCH = 16'h2000;
  // RETI is the format-II slot with opcode field [9:7] = 110.
  localparam logic [15:0] c_RETI_MASK  = 16'hFF80;
  localparam logic [15:0] c_RETI_MATCH = 16'h1300;

  // Source operand needs an extension word: indexed/symbolic/absolute
  // (As=01, not the R3 constant generator) or immediate (@PC+).
  function automatic logic src_ext(input logic [1:0] as_mode, input logic [3:0] rs);
    return ((as_mode == 2'b01) && (rs != 4'd3)) ||
           ((as_mode == 2'b11) && (rs == 4'd0));
  endfunction

  // Number of extension words that follow this opcode word (0..2).
  function automatic logic [1:0] ext_count(input logic [15:0] word);
    logic [1:0] n;
    n = 2'd0;
    if (word[15:14] != 2'b00) begin
      n = {1'b0, src_ext(word[5:4], word[11:8])} + {1'b0, word[7]};
    end else if (((word & c_FMT2_MASK) == c_FMT2_MATCH) &&
                 ((word & c_RETI_MASK) != c_RETI_MATCH)) begin
      n = {1'b0, src_ext(word[5:4], word[3:0])};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jump_unit.sv
`default_nettype none
// ============================================================================
// Module : jump_unit
// Brief  : Combinational format-III resolver: taken flag and branch target
//          for the word at i_pc, given SR flags {V,N,Z,C}.
// Rev    : 1.0 - initial release
// ============================================================================
module jump_unit
  import fetch_pkg::*;
(
  input  logic [15:0] i_opcode,
  input  logic [15:0] i_pc,
  input  logic [3:0]  i_flags,
  output logic        o_taken,
  output logic [15:0] o_target
);

  logic w_v, w_n, w_z, w_c;
  logic w_is_jump;
  logic w_cond_true;

  assign {w_v, w_n, w_z, w_c} = i_flags;
  assign w_is_jump = ((i_opcode & c_FMT3_MASK) == c_FMT3_MATCH);

  // Evaluate the branch condition encoded in [12:10].
  always_comb begin
    w_cond_true = 1'b0;
    case (i_opcode[12:10])
      c_COND_JNE: w_cond_true = ~w_z;
      c_COND_JEQ: w_cond_true = w_z;
      c_COND_JNC: w_cond_true = ~w_c;
      c_COND_JC:  w_cond_true = w_c;
      c_COND_JN:  w_cond_true = w_n;
      c_COND_JGE: w_cond_true = ~(w_n ^ w_v);
      c_COND_JL:  w_cond_true = w_n ^ w_v;
      c_COND_JMP: w_cond_true = 1'b1;
      default:    w_cond_true = 1'b0;
    endcase
  end

  assign o_taken  = w_is_jump & w_cond_true;
  // Word offset is relative to the following word; 16-bit add wraps.
  assign o_target = i_pc + 16'd2 + {{5{i_opcode[9]}}, i_opcode[9:0], 1'b0};

endmodule
`default_nettype wire

// File: rtl/instr_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_decode
// Brief  : Assembles MSP430 instructions (opcode + 0..2 extension words)
//          from the PC/word stream, resolves jumps back to the counter and
//          discards the two words already in flight after a taken jump.
// Rev    : 1.0 - initial release
// ============================================================================
module instr_fetch_decode
  import fetch_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] PC,
  input  logic        PC_ENA,
  input  logic [15:0] DATA,
  input  logic [3:0]  FLAGS,
  output logic        JMPE,
  output logic [15:0] JMP_ADDR,
  output logic        INSTR_VALID,
  output logic [15:0] INSTR,
  output logic [15:0] EXT1,
  output logic [15:0] EXT2,
  output logic [15:0] INSTR_PC,
  output logic [1:0]  INSTR_LEN
);

  fetch_state_t r_state;
  logic [15:0]  r_op;
  logic [15:0]  r_op_pc;
  logic [15:0]  r_ext1_hold;
  logic         r_need_two;

  logic         r_valid;
  logic         r_jmpe;
  logic [15:0]  r_jaddr;
  logic [15:0]  r_instr;
  logic [15:0]  r_ext1;
  logic [15:0]  r_ext2;
  logic [15:0]  r_ipc;
  logic [1:0]   r_len;

  logic [1:0]   w_n;
  logic         w_taken;
  logic [15:0]  w_target;

  assign w_n = ext_count(DATA);

  // Jump resolution uses the live word, PC and flags at the capturing edge.
  jump_unit u_jump_unit (
    .i_opcode (DATA),
    .i_pc     (PC),
    .i_flags  (FLAGS),
    .o_taken  (w_taken),
    .o_target (w_target)
  );

  // Word sequencing, instruction emission and post-jump flush.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_OPCODE;
      r_op        <= 16'd0;
      r_op_pc     <= 16'd0;
      r_ext1_hold <= 16'd0;
      r_need_two  <= 1'b0;
      r_valid     <= 1'b0;
      r_jmpe      <= 1'b0;
      r_jaddr     <= 16'd0;
      r_instr     <= 16'd0;
      r_ext1      <= 16'd0;
      r_ext2      <= 16'd0;
      r_ipc       <= 16'd0;
      r_len       <= 2'd0;
    end else begin
      r_valid <= 1'b0;
      r_jmpe  <= 1'b0;
      if (PC_ENA) begin
        case (r_state)
          ST_OPCODE: begin
            r_op       <= DATA;
            r_op_pc    <= PC;
            r_need_two <= (w_n == 2'd2);
            if (w_n == 2'd0) begin
              r_valid <= 1'b1;
              r_instr <= DATA;
              r_ext1  <= 16'd0;
              r_ext2  <= 16'd0;
              r_ipc   <= PC;
              r_len   <= 2'd1;
              if (w_taken) begin
                r_jmpe  <= 1'b1;
                r_jaddr <= w_target;
                r_state <= ST_FLUSH1;
              end
            end else begin
              r_state <= ST_EXT1;
            end
          end
          ST_EXT1: begin
            r_ext1_hold <= DATA;
            if (r_need_two) begin
              r_state <= ST_EXT2;
            end else begin
              r_valid <= 1'b1;
              r_instr <= r_op;
              r_ext1  <= DATA;
              r_ext2  <= 16'd0;
              r_ipc   <= r_op_pc;
              r_len   <= 2'd2;
              r_state <= ST_OPCODE;
            end
          end
          ST_EXT2: begin
            r_valid <= 1'b1;
            r_instr <= r_op;
            r_ext1  <= r_ext1_hold;
            r_ext2  <= DATA;
            r_ipc   <= r_op_pc;
            r_len   <= 2'd3;
            r_state <= ST_OPCODE;
          end
          ST_FLUSH1: r_state <= ST_FLUSH2;
          ST_FLUSH2: r_state <= ST_OPCODE;
          default:   r_state <= ST_OPCODE;
        endcase
      end
    end
  end

  assign JMPE        = r_jmpe;
  assign JMP_ADDR    = r_jaddr;
  assign INSTR_VALID = r_valid;
  assign INSTR       = r_instr;
  assign EXT1        = r_ext1;
  assign EXT2        = r_ext2;
  assign INSTR_PC    = r_ipc;
  assign INSTR_LEN   = r_len;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_fetch_decode
// Brief  : Self-checking bench for instr_fetch_decode: directed cases with
//          literal expectations plus randomized word streams against a
//          queue-based instruction model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_decode;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] PC;
  logic        PC_ENA;
  logic [15:0] DATA;
  logic [3:0]  FLAGS;
  logic        JMPE;
  logic [15:0] JMP_ADDR;
  logic        INSTR_VALID;
  logic [15:0] INSTR;
  logic [15:0] EXT1;
  logic [15:0] EXT2;
  logic [15:0] INSTR_PC;
  logic [1:0]  INSTR_LEN;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic [15:0] m_q[$];
  int          m_need;
  int          m_flush;
  logic [15:0] m_pc;
  // expected outputs after the next edge
  logic        e_valid, e_jmpe;
  logic [15:0] e_jaddr, e_instr, e_ext1, e_ext2, e_pc;
  logic [1:0]  e_len;

  instr_fetch_decode dut (
    .CLK(CLK), .RST_N(RST_N), .PC(PC), .PC_ENA(PC_ENA), .DATA(DATA),
    .FLAGS(FLAGS), .JMPE(JMPE), .JMP_ADDR(JMP_ADDR),
    .INSTR_VALID(INSTR_VALID), .INSTR(INSTR), .EXT1(EXT1), .EXT2(EXT2),
    .INSTR_PC(INSTR_PC), .INSTR_LEN(INSTR_LEN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Words consumed by a source operand in addressing mode as_m on register r.
  function automatic int src_words(input int as_m, input int r);
    if (r == 3) return 0;
    if (r == 2 && as_m >= 2) return 0;
    if (as_m == 1) return 1;
    if (as_m == 3 && r == 0) return 1;
    return 0;
  endfunction

  function automatic int ext_words(input logic [15:0] w);
    int as_m;
    as_m = int'(w[5:4]);
    if (w >= 16'h4000) return src_words(as_m, int'(w[11:8])) + int'(w[7]);
    if (w[15:10] == 6'b000100 && w[9:7] != 3'b110) return src_words(as_m, int'(w[3:0]));
    return 0;
  endfunction

  function automatic bit cond_true(input int c, input logic [3:0] f);
    bit v, n, z, cy;
    v = f[3]; n = f[2]; z = f[1]; cy = f[0];
    case (c)
      0: return !z;
      1: return z;
      2: return !cy;
      3: return cy;
      4: return n;
      5: return n == v;
      6: return n != v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_need = 0; m_flush = 0; m_pc = 16'd0;
    e_valid = 0; e_jmpe = 0; e_jaddr = 0; e_instr = 0;
    e_ext1 = 0; e_ext2 = 0; e_pc = 0; e_len = 0;
  endtask

  task automatic model_step(input logic ena, input logic [15:0] w,
                            input logic [15:0] p, input logic [3:0] f);
    int off, t;
    e_valid = 0; e_jmpe = 0;
    if (!ena) return;
    if (m_flush > 0) begin
      m_flush--;
      return;
    end
    if (m_q.size() == 0) begin
      m_pc   = p;
      m_need = 1 + ext_words(w);
    end
    m_q.push_back(w);
    if (m_q.size() == m_need) begin
      e_valid = 1;
      e_instr = m_q[0];
      e_ext1  = (m_need > 1) ? m_q[1] : 16'd0;
      e_ext2  = (m_need > 2) ? m_q[2] : 16'd0;
      e_pc    = m_pc;
      e_len   = 2'(m_need);
      if (m_q[0][15:13] == 3'b001 && cond_true(int'(m_q[0][12:10]), f)) begin
        off = int'(m_q[0][9:0]);
        if (off >= 512) off -= 1024;
        t = int'(m_pc) + 2 + 2 * off;
        e_jmpe  = 1;
        e_jaddr = 16'(t & 32'hFFFF);
        m_flush = 2;
      end
      m_q.delete();
    end
  endtask

  // Compare the registered outputs against the model after every edge.
  task automatic compare_all();
    chk("valid", {15'd0, INSTR_VALID}, {15'd0, e_valid});
    chk("jmpe", {15'd0, JMPE}, {15'd0, e_jmpe});
    chk("instr", INSTR, e_instr);
    chk("ext1", EXT1, e_ext1);
    chk("ext2", EXT2, e_ext2);
    chk("instr_pc", INSTR_PC, e_pc);
    chk("len", {14'd0, INSTR_LEN}, {14'd0, e_len});
    if (e_jmpe) chk("jmp_addr", JMP_ADDR, e_jaddr);
  endtask

  task automatic feed(input logic ena, input logic [15:0] w,
                      input logic [15:0] p, input logic [3:0] f);
    PC_ENA = ena; DATA = w; PC = p; FLAGS = f;
    model_step(ena, w, p, f);
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input string tag);
    PC_ENA = 1'b0;
    RST_N  = 1'b0;
    #2;
    chk({tag, "_valid"}, {15'd0, INSTR_VALID}, 16'd0);
    chk({tag, "_jmpe"}, {15'd0, JMPE}, 16'd0);
    chk({tag, "_jaddr"}, JMP_ADDR, 16'd0);
    chk({tag, "_instr"}, INSTR, 16'd0);
    chk({tag, "_ext1"}, EXT1, 16'd0);
    chk({tag, "_ext2"}, EXT2, 16'd0);
    chk({tag, "_pc"}, INSTR_PC, 16'd0);
    chk({tag, "_len"}, {14'd0, INSTR_LEN}, 16'd0);
    model_reset();
    #1 RST_N = 1'b1;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 5))
      0, 1: w[15:12] = 4'($urandom_range(4, 15));
      2:    w[15:10] = 6'b000100;
      3:    w[15:13] = 3'b001;
      4:    begin w[15:12] = 4'($urandom_range(4, 15)); w[11:8] = 4'($urandom_range(0, 3)); end
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    logic [15:0] cur_pc, tgt;
    int pend;
    RST_N = 1'b0; PC_ENA = 1'b0; DATA = 16'd0; PC = 16'd0; FLAGS = 4'd0;
    model_reset();
    #1;
    do_reset("rst0");
    @(posedge CLK); #1;

    // Immediate source
    feed(1, 16'h4031, 16'h0002, 4'h0);
    chk("imm_first_novalid", {15'd0, INSTR_VALID}, 16'd0);
    feed(1, 16'h0280, 16'h0004, 4'h0);
    chk("imm_valid", {15'd0, INSTR_VALID}, 16'd1);
    chk("imm_instr", INSTR, 16'h4031);
    chk("imm_ext1", EXT1, 16'h0280);
    chk("imm_ext2", EXT2, 16'h0000);
    chk("imm_len", {14'd0, INSTR_LEN}, 16'd2);
    chk("imm_pc", INSTR_PC, 16'h0002);
    feed(0, 16'hFFFF, 16'h0006, 4'h0);
    chk("idle_hold_instr", INSTR, 16'h4031);

    // Indexed both operands; constant-generator source
    feed(1, 16'h4596, 16'h0006, 4'h0);
    feed(1, 16'h0004, 16'h0008, 4'h0);
    feed(1, 16'h0006, 16'h000A, 4'h0);
    chk("idx_len", {14'd0, INSTR_LEN}, 16'd3);
    chk("idx_ext1", EXT1, 16'h0004);
    chk("idx_ext2", EXT2, 16'h0006);
    feed(1, 16'h4392, 16'h000C, 4'h0);
    feed(1, 16'h0200, 16'h000E, 4'h0);
    chk("cg_len", {14'd0, INSTR_LEN}, 16'd2);
    chk("cg_valid", {15'd0, INSTR_VALID}, 16'd1);

    // Unconditional jump with flush
    feed(1, 16'h3C03, 16'h0010, 4'h0);
    chk("jmp_jmpe", {15'd0, JMPE}, 16'd1);
    chk("jmp_addr_lit", JMP_ADDR, 16'h0018);
    feed(1, 16'h4303, 16'h0012, 4'h0);
    chk("flush1_novalid", {15'd0, INSTR_VALID}, 16'd0);
    feed(1, 16'h4303, 16'h0014, 4'h0);
    chk("flush2_novalid", {15'd0, INSTR_VALID}, 16'd0);
    feed(1, 16'h4303, 16'h0018, 4'h0);
    chk("after_jmp_pc", INSTR_PC, 16'h0018);

    // Conditional JEQ, not taken then taken
    feed(1, 16'h2402, 16'h0020, 4'b0000);
    chk("jeq_nt_jmpe", {15'd0, JMPE}, 16'd0);
    feed(1, 16'h4303, 16'h0022, 4'b0000);
    chk("jeq_nt_next_pc", INSTR_PC, 16'h0022);
    feed(1, 16'h2402, 16'h0020, 4'b0010);
    chk("jeq_t_jmpe", {15'd0, JMPE}, 16'd1);
    chk("jeq_t_addr", JMP_ADDR, 16'h0026);
    feed(1, 16'h4303, 16'h0022, 4'h0);
    feed(1, 16'h4303, 16'h0024, 4'h0);

    // Backward wrap
    feed(1, 16'h3FFD, 16'h0002, 4'h0);
    chk("wrap_addr", JMP_ADDR, 16'hFFFE);
    feed(1, 16'h4303, 16'h0004, 4'h0);
    feed(1, 16'h4303, 16'h0006, 4'h0);

    // Reset mid-instruction
    feed(1, 16'h4596, 16'h0040, 4'h0);
    do_reset("rst_mid");
    feed(1, 16'h4303, 16'h0050, 4'h0);
    chk("post_rst_valid", {15'd0, INSTR_VALID}, 16'd1);
    chk("post_rst_len", {14'd0, INSTR_LEN}, 16'd1);
    chk("post_rst_instr", INSTR, 16'h4303);

    // Randomized stream with a counter that follows taken jumps
    cur_pc = 16'h1000; pend = 0; tgt = 16'd0;
    for (int i = 0; i < 3000; i++) begin
      logic ena;
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rst_rand");
        pend = 0;
      end
      ena = ($urandom_range(0, 9) != 0);
      feed(ena, rand_word(), cur_pc, 4'($urandom));
      if (ena) begin
        if (e_jmpe) begin
          pend = 2; tgt = e_jaddr; cur_pc = cur_pc + 16'd2;
        end else if (pend > 0) begin
          pend--;
          cur_pc = (pend == 0) ? tgt : cur_pc + 16'd2;
        end else begin
          cur_pc = cur_pc + 16'd2;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Instruction fetch/decode stage directly downstream of the program counter. It consumes the PC/word stream (`PC`, `PC_ENA`, `DATA`) and assembles complete MSP430 instructions, including 0–2 extension words. It resolves format-III jumps and drives `JMPE`/`JMP_ADDR` back to the counter. It also discards the words already in flight after a taken jump.

## Interface
Parameters: none (16-bit MSP430 datapath fixed).

- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `PC` in 16: address of the word on `DATA`, from the counter.
- `PC_ENA` in 1: `PC`/`DATA` valid this cycle.
- `DATA` in 16: instruction-memory word at `PC`, same cycle.
- `FLAGS` in 4: {V,N,Z,C} from SR, sampled when a jump word is captured.
- `JMPE` out 1: taken-jump pulse to the counter.
- `JMP_ADDR` out 16: jump target, valid while `JMPE`=1.
- `INSTR_VALID` out 1: one-cycle pulse, complete instruction on outputs.
- `INSTR` out 16: opcode word.
- `EXT1`, `EXT2` out 16: extension words; 0 when absent.
- `INSTR_PC` out 16: address of the opcode word.
- `INSTR_LEN` out 2: word count, 1–3.

## Operation
- A word is accepted on each rising edge with `PC_ENA`=1. If `PC_ENA`=0, state and outputs hold and `INSTR_VALID`/`JMPE` are 0.
- States: OPCODE, EXT1, EXT2, FLUSH1, FLUSH2. Reset state is OPCODE.
- **OPCODE:** capture the word and `PC`, then compute the extension count n.
  - Format I (`DATA[15:12]`≥4) adds src ext and dst ext.
  - Format II (`DATA[15:10]`=000100; RETI excluded) adds src ext using As=[5:4] and reg=[3:0].
  - Format III (`[15:13]`=001) has n=0.
  - src ext=1 when As=01 and reg≠3, or As=11 and reg=0. R2 As=1x and R3 any As are constant-generator forms with no extension.
  - dst ext=1 when Ad (bit 7)=1.
- If n=0, emit. Otherwise go to EXT1. EXT1 goes to EXT2 if n=2, else emits. EXT2 emits.
- **Emit:** `INSTR_VALID`=1 for one cycle with all fields set. Unused EXT fields are 0. `INSTR_LEN`=n+1.
- **Jumps:**
  - Fields: cond=[12:10], offset=[9:0] signed.
  - Target = `INSTR_PC` + 2 + (sext(offset)<<1), modulo 2^16 (wraps silently).
  - Conditions:
    - 000 JNE: Z=0
    - 001 JEQ: Z=1
    - 010 JNC: C=0
    - 011 JC: C=1
    - 100 JN: N=1
    - 101 JGE: N⊕V=0
    - 110 JL: N⊕V=1
    - 111 JMP: always
  - Every jump is emitted with `INSTR_VALID`. If taken, `JMPE`=1 with `JMP_ADDR`=target in the same cycle, and the next state is FLUSH1.
- **FLUSH1/FLUSH2:** each discards exactly one accepted word, then FLUSH2 returns to OPCODE. Flushing is a fixed count, not an address match, so an offset-0 jump refetches correctly.
- There is no backpressure; the counter cannot stall and downstream must accept every pulse.
- `FLAGS` use the value present at the capturing edge. There is no forwarding from an execute write in the same cycle.

## Timing
- All outputs are registered. Reset values: `JMPE`=0, `JMP_ADDR`=0, `INSTR_VALID`=0, `INSTR`/`EXT1`/`EXT2`/`INSTR_PC`=0, `INSTR_LEN`=0.
- `INSTR_VALID` rises one cycle after the edge that accepts the instruction's last word.
- `JMPE` sequence:
  - `JMPE` is high for exactly one cycle after the jump word's edge.
  - The counter samples it on the next edge.
  - `PC` shows the target one cycle after that.
  - The two words in between (jump PC+2, PC+4) are discarded.
- Asserting `RST_N` low in any state immediately clears the outputs and sets the state to OPCODE. The first accepted word after release is decoded as an opcode.
- Fields hold their values between `INSTR_VALID` pulses.

## Structure
- Package `fetch_pkg`:
  - state enum
  - jump condition code constants
  - format opcode masks
  - function `ext_count(word)` returning 0–2
- Sub-module `jump_unit`: combinational. Inputs are opcode, PC and `FLAGS`; outputs are taken and target. It is reused for verification reference.

## Test plan
- **Immediate source:** 0x4031, 0x0280 from PC 0x0002 → one pulse with `INSTR`=0x4031, `EXT1`=0x0280, `EXT2`=0, `INSTR_LEN`=2, `INSTR_PC`=0x0002.
- **Indexed both operands:** 0x4596, 0x0004, 0x0006 → `INSTR_LEN`=3, `EXT1`=0x0004, `EXT2`=0x0006. Constant generator 0x4392 (MOV #1,&a), 0x0200 → `INSTR_LEN`=2.
- **Unconditional jump:** 0x3C03 at 0x0010 → `JMPE` pulse with `JMP_ADDR`=0x0018. Words at 0x0012 and 0x0014 produce no output, and the next `INSTR_PC`=0x0018.
- **Conditional jump:** JEQ 0x2402 at 0x0020. With Z=0 → no `JMPE` and the next word at 0x0022 is decoded. With Z=1 → `JMP_ADDR`=0x0026.
- **Backward wrap:** 0x3FFD at 0x0002 → `JMP_ADDR`=0xFFFE.
- **Reset mid-instruction:** reset pulsed while in EXT1 (after 0x4596) → all outputs 0. After release, 0x4303 is decoded as a length-1 opcode.
